// File: rtl/pm_pkg.sv
// Shared types and widths for the product normalize/round path.
package pm_pkg;

  localparam int PROD_W = 32;
  localparam int MANT_W = 16;
  localparam int EXP_W  = 6;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              inexact;
  } pm_norm_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero word counts as 32.
module lzc32 (
  input  logic [31:0] data_i,
  output logic [5:0]  count_o
);

  // Ascending scan so the highest set bit makes the final assignment.
  always_comb begin
    count_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) count_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/pm_norm_round.sv
// Two-stage normalize-and-round for the 32-bit multiplier product.
// Define PM_NORM_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module pm_norm_round
  import pm_pkg::*;
#(
  parameter int PROD_W = 32,
  parameter int MANT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_inexact
);

  logic              s1Valid_q, s1Valid_d;
  logic [PROD_W-1:0] s1Prod_q;
  logic [5:0]        s1Lz_q;
  logic              s2Valid_q, s2Valid_d;
  pm_norm_t          s2Res_q, s2Res_d;

  logic              s2Adv, s1Load, s2Load;
  logic [5:0]        lzCount;
  logic [PROD_W-1:0] norm;
  logic [MANT_W-1:0] mantT;
  logic [MANT_W:0]   mantSum;
  logic              guardBit, stickyBit, roundUp, carry;

  lzc32 u_lzc (
    .data_i  (in_prod),
    .count_o (lzCount)
  );

  // Each slot advances when the slot downstream of it is empty or draining.
  always_comb begin
    s2Adv     = !s2Valid_q | out_ready;
    in_ready  = !s1Valid_q | s2Adv;
    s1Load    = in_ready & in_valid;
    s2Load    = s2Adv & s1Valid_q;
    s1Valid_d = in_ready ? in_valid : s1Valid_q;
    s2Valid_d = s2Adv ? s1Valid_q : s2Valid_q;
  end

  always_comb begin
    norm      = s1Prod_q << s1Lz_q;
    mantT     = norm[PROD_W-1 -: MANT_W];
    guardBit  = norm[PROD_W-MANT_W-1];
    stickyBit = |norm[PROD_W-MANT_W-2:0];
`ifdef PM_NORM_RNE_EN
    roundUp   = guardBit & (stickyBit | mantT[0]);
`else
    roundUp   = 1'b0;
`endif
    mantSum   = {1'b0, mantT} + {{MANT_W{1'b0}}, roundUp};
    carry     = mantSum[MANT_W];
    s2Res_d         = '0;
    s2Res_d.inexact = guardBit | stickyBit;
    // An all-ones mantissa that rounds up renormalizes to 1.000 one binade higher.
    s2Res_d.mant    = carry ? {1'b1, {(MANT_W-1){1'b0}}} : mantSum[MANT_W-1:0];
    s2Res_d.exp     = 6'd31 - s1Lz_q + {5'd0, carry};
    if (s1Lz_q == 6'd32) begin
      s2Res_d      = '0;
      s2Res_d.zero = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      s1Prod_q  <= '0;
      s1Lz_q    <= '0;
      s2Res_q   <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
      if (s1Load) begin
        s1Prod_q <= in_prod;
        s1Lz_q   <= lzCount;
      end
      if (s2Load) s2Res_q <= s2Res_d;
    end
  end

  assign out_valid   = s2Valid_q;
  assign out_mant    = s2Res_q.mant;
  assign out_exp     = s2Res_q.exp;
  assign out_zero    = s2Res_q.zero;
  assign out_inexact = s2Res_q.inexact;

endmodule
